// File: rtl/keypad_scanner_if.sv
// Pad-side and core-side signals of the keypad scanner.
// The master modport is the scanner; the slave is the pad ring/calculator.
interface keypad_scanner_if;
   logic [3:0] row_in;
   logic [3:0] col_out;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   modport master (
      input  row_in,
      output col_out,
      output key_code,
      output key_valid,
      output key_held
   );

   modport slave (
      output row_in,
      input  col_out,
      input  key_code,
      input  key_valid,
      input  key_held
   );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column scan, full-scan debounce, and one strobe per press.
// key_code = row*4 + col of the accepted key.
module keypad_scanner #(
   parameter int SCAN_DIV       = 2500,
   parameter int DEBOUNCE_SCANS = 8
) (
   input logic              clk,
   input logic              rst_n,
   keypad_scanner_if.master kp
);

   localparam int              DIV_W    = $clog2(SCAN_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [3:0]       DEB      = 4'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {
      RES_NONE,
      RES_SINGLE,
      RES_MULTI
   } res_kind_t;

   typedef enum logic {
      IDLE,
      PRESSED
   } state_t;

   logic [3:0]       row_meta;
   logic [3:0]       row_sync;
   logic [DIV_W-1:0] div_q;
   logic [1:0]       col_q;
   logic             sample_en;
   logic             scan_done;
   logic [15:0]      snapshot_q;
   logic [15:0]      scan_full;
   logic [4:0]       ones;
   logic [3:0]       hit_idx;
   res_kind_t        res_kind;
   logic [3:0]       res_idx;
   res_kind_t        prev_kind_q;
   logic [3:0]       prev_idx_q;
   logic             same_res;
   logic [3:0]       cnt_q;
   logic [3:0]       cnt_next;
   state_t           state_q;
   state_t           state_d;
   logic             key_valid_q;
   logic             key_valid_d;
   logic [3:0]       key_code_q;
   logic [3:0]       key_code_d;

   // Rows idle high (external pull-ups), so the synchroniser resets to all ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_meta <= 4'hF;
         row_sync <= 4'hF;
      end else begin
         row_meta <= kp.row_in;
         row_sync <= row_meta;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q <= '0;
         col_q <= 2'd0;
      end else if (div_q == DIV_LAST) begin
         div_q <= '0;
         col_q <= col_q + 2'd1;
      end else begin
         div_q <= div_q + 1'b1;
      end
   end

   assign sample_en = (div_q == DIV_LAST);
   assign scan_done = sample_en && (col_q == 2'd3);

   // The column-3 sample is merged in combinationally so the result is known that cycle.
   always_comb begin
      scan_full = snapshot_q;
      if (sample_en) begin
         for (int r = 0; r < 4; r++) begin
            scan_full[{2'(r), col_q}] = ~row_sync[r];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snapshot_q <= '0;
      end else if (sample_en) begin
         snapshot_q <= scan_done ? 16'h0000 : scan_full;
      end
   end

   always_comb begin
      ones    = 5'd0;
      hit_idx = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (scan_full[i]) begin
            ones    = ones + 5'd1;
            hit_idx = 4'(i);
         end
      end
      if (ones == 5'd0) begin
         res_kind = RES_NONE;
      end else if (ones == 5'd1) begin
         res_kind = RES_SINGLE;
      end else begin
         res_kind = RES_MULTI;
      end
      res_idx = (ones == 5'd1) ? hit_idx : 4'd0;
   end

   // Non-single results always carry index 0, so a plain compare matches kind and key.
   assign same_res = (res_kind == prev_kind_q) && (res_idx == prev_idx_q);

   always_comb begin
      cnt_next = 4'd1;
      if (same_res) begin
         cnt_next = (cnt_q == DEB) ? DEB : cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_kind_q <= RES_NONE;
         prev_idx_q  <= 4'd0;
         cnt_q       <= 4'd0;
      end else if (scan_done) begin
         prev_kind_q <= res_kind;
         prev_idx_q  <= res_idx;
         cnt_q       <= cnt_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         key_valid_q <= 1'b0;
         key_code_q  <= 4'd0;
      end else begin
         state_q     <= state_d;
         key_valid_q <= key_valid_d;
         key_code_q  <= key_code_d;
      end
   end

   // Multi-key results never move the FSM; a key change while pressed needs a release first.
   always_comb begin
      state_d     = state_q;
      key_valid_d = 1'b0;
      key_code_d  = key_code_q;
      if (scan_done && (cnt_next == DEB)) begin
         case (state_q)
            IDLE: begin
               if (res_kind == RES_SINGLE) begin
                  state_d     = PRESSED;
                  key_valid_d = 1'b1;
                  key_code_d  = res_idx;
               end
            end
            PRESSED: begin
               if (res_kind == RES_NONE) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign kp.col_out   = ~(4'b0001 << col_q);
   assign kp.key_code  = key_code_q;
   assign kp.key_valid = key_valid_q;
   assign kp.key_held  = (state_q == PRESSED);

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model drives rows from the pressed-key set,
// expected strobes are queued and matched against every key_valid seen.
module tb_keypad_scanner;

   localparam int SCAN_DIV = 4;
   localparam int DEB      = 3;

   typedef struct {
      int         cycle;
      logic [3:0] code;
   } strobe_t;

   typedef struct {
      int          cycle;
      logic [15:0] keys;
      logic [3:0]  exp_col;
      logic        exp_held;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] keys = 16'h0000;
   logic [3:0]  rows;
   int          cyc;
   int          checks = 0;
   int          errors = 0;
   strobe_t     exp_q[$];
   strobe_t     got_exp;
   vec_t        tbl[17];
   logic [3:0]  col_pat[4];

   keypad_scanner_if kp ();

   keypad_scanner #(
      .SCAN_DIV       (SCAN_DIV),
      .DEBOUNCE_SCANS (DEB)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .kp    (kp)
   );

   always #5 clk = ~clk;

   // A pressed key shorts its row low while its column is driven.
   always_comb begin
      rows = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (!kp.col_out[c] && keys[r*4+c]) rows[r] = 1'b0;
         end
      end
   end
   assign kp.row_in = rows;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && kp.key_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_strobe: got code %0d at cycle %0d, expected no strobe", kp.key_code, cyc);
         end else begin
            got_exp = exp_q.pop_front();
            check_output("strobe_cycle", 32'(cyc), 32'(got_exp.cycle));
            check_output("strobe_code", 32'(kp.key_code), 32'(got_exp.code));
         end
      end
   end

   task automatic wait_cycle(input int n);
      int guard = 0;
      while (cyc != n) begin
         @(negedge clk);
         guard++;
         if (guard > 20000) begin
            $display("[TB] FAIL wait_timeout: got cycle %0d, expected %0d", cyc, n);
            $fatal(1, "[TB] bench stuck");
         end
      end
      #1;
   endtask

   task automatic apply_stimulus(input logic [15:0] k);
      keys = k;
   endtask

   task automatic expect_strobe(input int cycle, input logic [3:0] code);
      strobe_t s;
      s.cycle = cycle;
      s.code  = code;
      exp_q.push_back(s);
   endtask

   task automatic do_reset(input logic [15:0] k);
      rst_n = 1'b0;
      apply_stimulus(k);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic finish_scenario(input string name);
      check_output({name, "_pending_strobes"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      col_pat[0] = 4'b1110;
      col_pat[1] = 4'b1101;
      col_pat[2] = 4'b1011;
      col_pat[3] = 4'b0111;
      for (int i = 0; i < 17; i++) begin
         tbl[i].cycle    = i;
         tbl[i].keys     = 16'h0000;
         tbl[i].exp_col  = col_pat[(i / 4) % 4];
         tbl[i].exp_held = 1'b0;
      end

      // Reset state and column rotation
      repeat (2) @(negedge clk);
      check_output("rst_col_out", 32'(kp.col_out), 32'h0000000E);
      check_output("rst_key_code", 32'(kp.key_code), 32'd0);
      check_output("rst_key_valid", 32'(kp.key_valid), 32'd0);
      check_output("rst_key_held", 32'(kp.key_held), 32'd0);
      do_reset(16'h0000);
      for (int i = 0; i < 17; i++) begin
         wait_cycle(tbl[i].cycle);
         apply_stimulus(tbl[i].keys);
         check_output($sformatf("col_out_c%0d", tbl[i].cycle), 32'(kp.col_out), 32'(tbl[i].exp_col));
         check_output($sformatf("held_c%0d", tbl[i].cycle), 32'(kp.key_held), 32'(tbl[i].exp_held));
      end
      wait_cycle(70);
      finish_scenario("idle");

      // Single press of key 9, release, then key 3
      do_reset(16'h0200);
      expect_strobe(48, 4'd9);
      wait_cycle(47);
      check_output("press9_held_before", 32'(kp.key_held), 32'd0);
      wait_cycle(48);
      check_output("press9_valid", 32'(kp.key_valid), 32'd1);
      check_output("press9_held", 32'(kp.key_held), 32'd1);
      check_output("press9_code", 32'(kp.key_code), 32'd9);
      wait_cycle(49);
      check_output("press9_valid_drop", 32'(kp.key_valid), 32'd0);
      wait_cycle(64);
      apply_stimulus(16'h0000);
      wait_cycle(111);
      check_output("release_held_before", 32'(kp.key_held), 32'd1);
      wait_cycle(112);
      check_output("release_held_after", 32'(kp.key_held), 32'd0);
      check_output("release_code_kept", 32'(kp.key_code), 32'd9);
      wait_cycle(128);
      expect_strobe(176, 4'd3);
      apply_stimulus(16'h0008);
      wait_cycle(175);
      check_output("press3_held_before", 32'(kp.key_held), 32'd0);
      check_output("press3_code_before", 32'(kp.key_code), 32'd9);
      wait_cycle(176);
      check_output("press3_held", 32'(kp.key_held), 32'd1);
      check_output("press3_code", 32'(kp.key_code), 32'd3);
      wait_cycle(200);
      finish_scenario("press_release");

      // Bounce: key 5 toggles each scan for 6 scans, then held
      do_reset(16'h0020);
      expect_strobe(144, 4'd5);
      for (int s = 1; s <= 6; s++) begin
         wait_cycle(16 * s);
         apply_stimulus((s % 2 == 1) ? 16'h0000 : 16'h0020);
      end
      wait_cycle(143);
      check_output("bounce_held_before", 32'(kp.key_held), 32'd0);
      wait_cycle(144);
      check_output("bounce_held", 32'(kp.key_held), 32'd1);
      check_output("bounce_code", 32'(kp.key_code), 32'd5);
      wait_cycle(170);
      finish_scenario("bounce");

      // Multi-key: keys 0 and 15, then key 15 released
      do_reset(16'h8001);
      wait_cycle(95);
      check_output("multi_held", 32'(kp.key_held), 32'd0);
      check_output("multi_valid", 32'(kp.key_valid), 32'd0);
      wait_cycle(96);
      expect_strobe(144, 4'd0);
      apply_stimulus(16'h0001);
      wait_cycle(143);
      check_output("multi_rel_held_before", 32'(kp.key_held), 32'd0);
      wait_cycle(144);
      check_output("multi_rel_held", 32'(kp.key_held), 32'd1);
      check_output("multi_rel_code", 32'(kp.key_code), 32'd0);
      wait_cycle(170);
      finish_scenario("multi");

      // Reset while key 9 is pressed
      do_reset(16'h0200);
      expect_strobe(48, 4'd9);
      wait_cycle(60);
      check_output("midrst_held_before", 32'(kp.key_held), 32'd1);
      check_output("midrst_col_before", 32'(kp.col_out), 32'h00000007);
      #2;
      rst_n = 1'b0;
      #1;
      check_output("midrst_col", 32'(kp.col_out), 32'h0000000E);
      check_output("midrst_held", 32'(kp.key_held), 32'd0);
      check_output("midrst_valid", 32'(kp.key_valid), 32'd0);
      check_output("midrst_code", 32'(kp.key_code), 32'd0);
      finish_scenario("midrst_first");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      expect_strobe(48, 4'd9);
      wait_cycle(47);
      check_output("repress_held_before", 32'(kp.key_held), 32'd0);
      wait_cycle(48);
      check_output("repress_held", 32'(kp.key_held), 32'd1);
      check_output("repress_code", 32'(kp.key_code), 32'd9);
      wait_cycle(70);
      finish_scenario("midrst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
